// File: rtl/dm_cmd_pkg.sv
// Shared definitions for the DataMover MM2S command path: command field layout,
// status bit positions, FSM state encoding and the command packing helper.
package dm_cmd_pkg;

   localparam int BTT_W       = 23;
   localparam int TYPE_BIT    = 23;
   localparam int DSA_LSB     = 24;
   localparam int DSA_W       = 6;
   localparam int EOF_BIT     = 30;
   localparam int DRR_BIT     = 31;
   localparam int ADDR_LSB    = 32;
   localparam int TAG_W       = 4;
   localparam int RSVD_W      = 4;
   localparam int CMD_EXTRA_W = 40;
   localparam int MAX_CMD_W   = 64 + CMD_EXTRA_W;

   localparam int STS_OK_BIT     = 7;
   localparam int STS_SLVERR_BIT = 6;
   localparam int STS_DECERR_BIT = 5;
   localparam int STS_INTERR_BIT = 4;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ISSUE = 1'b1;

   // Builds a command for the widest address; callers keep the low addr_w+40 bits.
   function automatic logic [MAX_CMD_W-1:0] pack_mm2s_cmd(
      input logic [TAG_W-1:0] tag,
      input logic [63:0]      addr,
      input int               addr_w,
      input logic             eof,
      input logic [BTT_W-1:0] btt
   );
      logic [MAX_CMD_W-1:0] cmd;
      logic [63:0]          addr_mask;
      cmd                    = '0;
      addr_mask              = (addr_w >= 64) ? '1 : ((64'd1 << addr_w) - 64'd1);
      cmd[BTT_W-1:0]         = btt;
      cmd[TYPE_BIT]          = 1'b1;
      cmd[DSA_LSB +: DSA_W]  = '0;
      cmd[EOF_BIT]           = eof;
      cmd[DRR_BIT]           = 1'b0;
      cmd = cmd | (MAX_CMD_W'(addr & addr_mask) << ADDR_LSB);
      cmd = cmd | (MAX_CMD_W'({{RSVD_W{1'b0}}, tag}) << (ADDR_LSB + addr_w));
      return cmd;
   endfunction

endpackage

// File: rtl/dm_cmd_credit_ctr.sv
// Outstanding-command counter: up on command issue, down on status return,
// never below zero, with a full flag at the configured limit.
module dm_cmd_credit_ctr
   import dm_cmd_pkg::*;
#(
   parameter int MAX_COUNT = 8,
   parameter int CNT_W     = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic dec,
   output logic full
);

   logic [CNT_W-1:0] count_q;
   logic             do_inc;
   logic             do_dec;

   // A status beat with nothing outstanding is dropped rather than wrapping.
   assign do_inc = inc && (count_q != CNT_W'(MAX_COUNT));
   assign do_dec = dec && (count_q != '0);
   assign full   = (count_q == CNT_W'(MAX_COUNT));

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else if (do_inc && !do_dec) begin
         count_q <= count_q + 1'b1;
      end else if (do_dec && !do_inc) begin
         count_q <= count_q - 1'b1;
      end
   end

endmodule

// File: rtl/dm_read_cmd_splitter.sv
// Splits (address, length) read requests into DataMover MM2S commands at MAX_BTT and
// BOUNDARY_BYTES boundaries. Define READ_CMD_CREDIT_EN to add status ports and an issue credit limit.
module dm_read_cmd_splitter
   import dm_cmd_pkg::*;
#(
   parameter int ADDR_W          = 32,
   parameter int LEN_W           = 32,
   parameter int MAX_BTT         = 2048,
   parameter int BOUNDARY_BYTES  = 4096,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                     address_in_aclk,
   input  logic                     address_in_areset,
   input  logic [ADDR_W+LEN_W-1:0]  address_in_tdata,
   input  logic                     address_in_tvalid,
   output logic                     address_in_tready,
   output logic [ADDR_W+39:0]       command_out_tdata,
   output logic                     command_out_tvalid,
   input  logic                     command_out_tready
`ifdef READ_CMD_CREDIT_EN
   ,
   input  logic [7:0]               status_in_tdata,
   input  logic                     status_in_tvalid,
   output logic                     status_in_tready,
   output logic                     status_err
`endif
);

   localparam int CMD_W  = ADDR_W + CMD_EXTRA_W;
   localparam int B_MASK = BOUNDARY_BYTES - 1;

   logic [0:0]        state;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  rem_q;
   logic [LEN_W-1:0]  chunk_q;
   logic [TAG_W-1:0]  tag_q;
   logic              pend_q;
   logic [CMD_W-1:0]  cmd_q;

   logic [ADDR_W-1:0] req_addr;
   logic [LEN_W-1:0]  req_len;
   logic [LEN_W-1:0]  req_chunk;
   logic [ADDR_W-1:0] addr_nxt;
   logic [LEN_W-1:0]  rem_nxt;
   logic [LEN_W-1:0]  chunk_nxt;
   logic [TAG_W-1:0]  tag_nxt;
   logic [CMD_W-1:0]  cmd_first;
   logic [CMD_W-1:0]  cmd_next;
   logic              req_fire;
   logic              cmd_fire;
   logic              issue_ok;

   // Largest chunk that fits the remaining length, MAX_BTT and the next boundary.
   function automatic logic [LEN_W-1:0] chunk_of(
      input logic [ADDR_W-1:0] a,
      input logic [LEN_W-1:0]  rem
   );
      logic [LEN_W-1:0] to_bound;
      logic [LEN_W-1:0] lim;
      to_bound = LEN_W'(BOUNDARY_BYTES) - LEN_W'(a & ADDR_W'(B_MASK));
      lim      = (to_bound < LEN_W'(MAX_BTT)) ? to_bound : LEN_W'(MAX_BTT);
      return (rem < lim) ? rem : lim;
   endfunction

   assign req_addr  = address_in_tdata[ADDR_W-1:0];
   assign req_len   = address_in_tdata[ADDR_W +: LEN_W];
   assign req_chunk = chunk_of(req_addr, req_len);
   assign addr_nxt  = addr_q + ADDR_W'(chunk_q);
   assign rem_nxt   = rem_q - chunk_q;
   assign chunk_nxt = chunk_of(addr_nxt, rem_nxt);
   assign tag_nxt   = tag_q + 1'b1;

   always_comb begin
      cmd_first = CMD_W'(pack_mm2s_cmd(tag_q, 64'(req_addr), ADDR_W,
                                       req_chunk == req_len, BTT_W'(req_chunk)));
      cmd_next  = CMD_W'(pack_mm2s_cmd(tag_nxt, 64'(addr_nxt), ADDR_W,
                                       chunk_nxt == rem_nxt, BTT_W'(chunk_nxt)));
   end

   assign address_in_tready  = (state == ST_IDLE) && !address_in_areset;
   assign command_out_tvalid = pend_q && issue_ok;
   assign command_out_tdata  = cmd_q;
   assign req_fire           = address_in_tvalid && address_in_tready;
   assign cmd_fire           = command_out_tvalid && command_out_tready;

   // The next command is prepared on each handshake so tdata only changes when consumed.
   always_ff @(posedge address_in_aclk) begin
      if (address_in_areset) begin
         state   <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         chunk_q <= '0;
         tag_q   <= '0;
         pend_q  <= 1'b0;
         cmd_q   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_fire && (req_len != '0)) begin
                  addr_q  <= req_addr;
                  rem_q   <= req_len;
                  chunk_q <= req_chunk;
                  cmd_q   <= cmd_first;
                  pend_q  <= 1'b1;
                  state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (cmd_fire) begin
                  tag_q   <= tag_nxt;
                  addr_q  <= addr_nxt;
                  rem_q   <= rem_nxt;
                  chunk_q <= chunk_nxt;
                  if (rem_nxt == '0) begin
                     pend_q <= 1'b0;
                     state  <= ST_IDLE;
                  end else begin
                     cmd_q  <= cmd_next;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef READ_CMD_CREDIT_EN
   logic credit_full;
   logic unused_status_bits;

   assign unused_status_bits = ^{status_in_tdata[STS_OK_BIT], status_in_tdata[3:0]};
   assign status_in_tready   = 1'b1;
   assign issue_ok           = !credit_full;

   dm_cmd_credit_ctr #(
      .MAX_COUNT (MAX_OUTSTANDING),
      .CNT_W     (4)
   ) u_credit (
      .clk   (address_in_aclk),
      .reset (address_in_areset),
      .inc   (cmd_fire),
      .dec   (status_in_tvalid),
      .full  (credit_full)
   );

   always_ff @(posedge address_in_aclk) begin
      if (address_in_areset) begin
         status_err <= 1'b0;
      end else if (status_in_tvalid && (status_in_tdata[STS_SLVERR_BIT] ||
                   status_in_tdata[STS_DECERR_BIT] || status_in_tdata[STS_INTERR_BIT])) begin
         status_err <= 1'b1;
      end
   end
`else
   // No issue limit without the credit feature; legal MAX_OUTSTANDING is always positive.
   assign issue_ok = (MAX_OUTSTANDING > 0);
`endif

endmodule
